// File: rtl/fir_mac_sched_pkg.sv
// Shared types and default parameters for the FIR MAC sequencer.
package fir_mac_sched_pkg;

  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_PH_W       = 2;
  localparam int DEF_PIPE_DELAY = 6;
  localparam int DEF_CTR_PHASE  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Frame markers carried alongside each MAC issue slot.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic ctr;
  } ctl_t;

endpackage

// File: rtl/fir_mac_sched_if.sv
// Control/status bundle between the sample-rate side and the MAC sequencer.
// Optional: FIR_MAC_SCHED_DROP_CNT_EN adds the drop_cnt status field.
interface fir_mac_sched_if
  import fir_mac_sched_pkg::*;
#(
  parameter int PH_W = DEF_PH_W
) ();

  logic            sam_en;
  logic            run;
  logic            ovr_clr;
  logic [PH_W-1:0] tap_sel;
  logic            ctr_sel;
  logic            acc_clr;
  logic            acc_en;
  logic            out_valid;
  logic            busy;
  logic            overrun;
`ifdef FIR_MAC_SCHED_DROP_CNT_EN
  logic [7:0]      drop_cnt;
`endif

  modport master (
    output sam_en, run, ovr_clr,
    input  tap_sel, ctr_sel, acc_clr, acc_en, out_valid, busy, overrun
`ifdef FIR_MAC_SCHED_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  sam_en, run, ovr_clr,
    output tap_sel, ctr_sel, acc_clr, acc_en, out_valid, busy, overrun
`ifdef FIR_MAC_SCHED_DROP_CNT_EN
    , output drop_cnt
`endif
  );

endinterface

// File: rtl/fir_mac_sched_ctl_delay_line.sv
// Fixed-depth shift register that aligns frame markers with the MAC datapath latency.
module ctl_delay_line
  import fir_mac_sched_pkg::*;
#(
  parameter int DEPTH = DEF_PIPE_DELAY
) (
  input  logic clk,
  input  logic reset_n,
  input  ctl_t din,
  output ctl_t dout,
  output logic any_valid
);

  ctl_t stage_q [DEPTH];
  ctl_t stage_d [DEPTH];

  // Each stage takes the previous one; stage 0 takes the issue-stage markers.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  // Stage registers, cleared on reset so an aborted frame leaves no trace.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  // Any slot still in flight keeps the sequencer reporting busy.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage_q[i].valid;
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sched.sv
// Time-shared FIR MAC sequencer: steps tap_sel per sample strobe and drives the accumulator.
// Optional: FIR_MAC_SCHED_DROP_CNT_EN adds a saturating count of dropped strobes.
module fir_mac_sched
  import fir_mac_sched_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int PH_W       = DEF_PH_W,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY,
  parameter int CTR_PHASE  = DEF_CTR_PHASE
) (
  input logic             clk,
  input logic             reset_n,
  fir_mac_sched_if.slave  bus
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0] CTR_PH  = PH_W'(CTR_PHASE);

  state_t          state_q, state_d;
  logic [PH_W-1:0] tap_sel_q, tap_sel_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            out_valid_q, out_valid_d;
  ctl_t            issue_q, issue_d;
  logic            start;
  logic            drop;
  ctl_t            pipe_out;
  logic            pipe_busy;
  logic            unused_pipe_ctr;

  // Next-state: frame start/advance, one-deep strobe queue, drop detection.
  always_comb begin
    state_d   = state_q;
    tap_sel_d = tap_sel_q;
    pending_d = pending_q;
    issue_d   = '0;
    start     = 1'b0;
    drop      = 1'b0;
    case (state_q)
      IDLE: begin
        if ((bus.sam_en | pending_q) & bus.run) start = 1'b1;
      end
      ISSUE: begin
        if (tap_sel_q != LAST_PH) begin
          tap_sel_d     = tap_sel_q + PH_W'(1);
          issue_d.valid = 1'b1;
          if (bus.sam_en) begin
            if (pending_q) drop = 1'b1;
            else           pending_d = 1'b1;
          end
        end else if ((bus.sam_en | pending_q) & bus.run) begin
          start = 1'b1;
        end else begin
          state_d = IDLE;
          if (bus.sam_en) begin
            if (pending_q) drop = 1'b1;
            else           pending_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A strobe arriving alongside a consumed pending one becomes the new pending.
    if (start) begin
      state_d       = ISSUE;
      tap_sel_d     = '0;
      pending_d     = pending_q & bus.sam_en;
      issue_d.valid = 1'b1;
      issue_d.first = 1'b1;
    end
    issue_d.last = issue_d.valid & (tap_sel_d == LAST_PH);
    issue_d.ctr  = issue_d.valid & (tap_sel_d == CTR_PH);
    overrun_d    = drop | (overrun_q & ~bus.ovr_clr);
    out_valid_d  = pipe_out.last;
  end

  // Sequencer registers; all outputs come straight from these flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tap_sel_q   <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      issue_q     <= '0;
    end else begin
      state_q     <= state_d;
      tap_sel_q   <= tap_sel_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      issue_q     <= issue_d;
    end
  end

  ctl_delay_line #(
    .DEPTH(PIPE_DELAY)
  ) u_ctl_delay (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (issue_q),
    .dout      (pipe_out),
    .any_valid (pipe_busy)
  );

  // The delayed centre marker travels with the frame but the accumulator has no use for it.
  assign unused_pipe_ctr = pipe_out.ctr;

  assign bus.tap_sel   = tap_sel_q;
  assign bus.ctr_sel   = issue_q.ctr;
  assign bus.acc_clr   = pipe_out.first;
  assign bus.acc_en    = pipe_out.valid;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE) | pipe_busy;
  assign bus.overrun   = overrun_q;

`ifdef FIR_MAC_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop count; a drop coinciding with a clear restarts the count at 1.
  always_comb begin
    drop_cnt_d = bus.ovr_clr ? 8'd0 : drop_cnt_q;
    if (drop) begin
      if (bus.ovr_clr)              drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= 8'd0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: a constant table, directed corner sequences and
// randomized traffic compared with a frame-scheduling reference model.
module tb_fir_mac_sched;
  import fir_mac_sched_pkg::*;

  localparam int N    = DEF_NUM_PHASES;
  localparam int PH_W = DEF_PH_W;
  localparam int PD   = DEF_PIPE_DELAY;
  localparam int CTR  = DEF_CTR_PHASE;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fir_mac_sched_if #(.PH_W(PH_W)) bus ();

  fir_mac_sched #(
    .NUM_PHASES(N), .PH_W(PH_W), .PIPE_DELAY(PD), .CTR_PHASE(CTR)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: expected outputs per cycle, scheduled whole frames at a time.
  int m_tap  [MAXC];
  bit m_ctr  [MAXC];
  bit m_clr  [MAXC];
  bit m_en   [MAXC];
  bit m_ov   [MAXC];
  bit m_busy [MAXC];
  bit m_active, m_pend, m_ovr;
  int m_start, m_cnt, m_cur_tap;

  // Observed outputs per cycle for the directed sequences.
  int o_tap  [MAXC];
  bit o_clr  [MAXC];
  bit o_ov   [MAXC];
  bit o_busy [MAXC];
  bit o_ovr  [MAXC];

  typedef struct packed {
    logic sam, run, clr;
    logic [PH_W-1:0] tap;
    logic ctr, aclr, aen, ov, busy, ovr;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < MAXC; i++) begin
      m_tap[i] = -1; m_ctr[i] = 0; m_clr[i] = 0; m_en[i] = 0; m_ov[i] = 0; m_busy[i] = 0;
      o_tap[i] = -1; o_clr[i] = 0; o_ov[i] = 0; o_busy[i] = 0; o_ovr[i] = 0;
    end
    m_active = 0; m_pend = 0; m_ovr = 0; m_start = 0; m_cnt = 0; m_cur_tap = 0;
  endfunction

  // A frame accepted at edge t occupies phases in cycles t+1..t+N and accumulates PD later.
  function automatic void modelStart(input int t);
    m_active = 1;
    m_start  = t;
    for (int p = 0; p < N; p++) begin
      m_tap[t+1+p]  = p;
      m_ctr[t+1+p]  = (p == CTR);
      m_en[t+1+PD+p] = 1;
    end
    m_clr[t+1+PD]  = 1;
    m_ov[t+1+PD+N] = 1;
    for (int c = t + 1; c <= t + PD + N; c++) m_busy[c] = 1;
  endfunction

  function automatic void modelEdge(input int t, input bit s, input bit r, input bit c);
    bit drop;
    drop = 0;
    if (!m_active) begin
      if ((s | m_pend) & r) begin m_pend = m_pend & s; modelStart(t); end
    end else if (t != m_start + N) begin
      if (s) begin if (m_pend) drop = 1; else m_pend = 1; end
    end else if ((s | m_pend) & r) begin
      m_pend = m_pend & s;
      modelStart(t);
    end else begin
      m_active = 0;
      if (s) begin if (m_pend) drop = 1; else m_pend = 1; end
    end
    m_ovr = drop | (m_ovr & ~c);
    if (drop) m_cnt = c ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    else if (c) m_cnt = 0;
  endfunction

  task automatic checkOutput();
    logic [15:0] act, exp;
    if (m_tap[edge_n] >= 0) m_cur_tap = m_tap[edge_n];
`ifdef FIR_MAC_SCHED_DROP_CNT_EN
    act[15:8] = bus.drop_cnt;
    exp[15:8] = 8'(m_cnt);
`else
    act[15:8] = 8'd0;
    exp[15:8] = 8'd0;
`endif
    act[7:0] = {bus.tap_sel, bus.ctr_sel, bus.acc_clr, bus.acc_en, bus.out_valid, bus.busy, bus.overrun};
    exp[7:0] = {PH_W'(m_cur_tap), m_ctr[edge_n], m_clr[edge_n], m_en[edge_n], m_ov[edge_n],
                m_busy[edge_n], m_ovr};
    check($sformatf("model cycle %0d", edge_n), 32'(act), 32'(exp));
    o_tap[edge_n]  = int'(bus.tap_sel);
    o_clr[edge_n]  = bus.acc_clr;
    o_ov[edge_n]   = bus.out_valid;
    o_busy[edge_n] = bus.busy;
    o_ovr[edge_n]  = bus.overrun;
  endtask

  // Drive one cycle of inputs, advance the model across the edge and compare after it.
  task automatic applyStimulus(input bit s, input bit r, input bit c);
    bus.sam_en  = s;
    bus.run     = r;
    bus.ovr_clr = c;
    modelEdge(edge_n, s, r, c);
    @(posedge clk);
    #1;
    edge_n++;
    checkOutput();
  endtask

  // Assert reset between edges, confirm outputs clear at once, release before the next edge.
  task automatic doReset();
    logic [7:0] outs;
    reset_n = 1'b0;
    #2;
    outs = {bus.tap_sel, bus.ctr_sel, bus.acc_clr, bus.acc_en, bus.out_valid, bus.busy, bus.overrun};
    check("reset outputs", 32'(outs), 32'd0);
    bus.sam_en = 0; bus.run = 0; bus.ovr_clr = 0;
    modelReset();
    edge_n = 0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt;
    bus.sam_en = 0; bus.run = 0; bus.ovr_clr = 0;
    modelReset();
    @(posedge clk);
    #1;
    doReset();

    // Single frame against hand-derived constants: row i drives cycle i, expects cycle i+1.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      logic [7:0] act;
      applyStimulus(tbl[i].sam, tbl[i].run, tbl[i].clr);
      act = {bus.tap_sel, bus.ctr_sel, bus.acc_clr, bus.acc_en, bus.out_valid, bus.busy, bus.overrun};
      check($sformatf("table row %0d", i), 32'(act), 32'(tbl[i][7:0]));
    end

    // Back-to-back frames with no bubble.
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(i == 0 || i == 4, 1, 0);
    for (int c = 1; c <= 8; c++) check($sformatf("b2b tap c%0d", c), 32'(o_tap[c]), 32'((c - 1) % 4));
    check("b2b acc_clr c7", 32'(o_clr[7]), 32'd1);
    check("b2b acc_clr c11", 32'(o_clr[11]), 32'd1);
    check("b2b out_valid c11", 32'(o_ov[11]), 32'd1);
    check("b2b out_valid c15", 32'(o_ov[15]), 32'd1);
    check("b2b overrun", 32'(o_ovr[20]), 32'd0);

    // Overrun: third strobe dropped, pending frame follows, ovr_clr releases the flag.
    doReset();
    for (int i = 0; i < 24; i++) applyStimulus(i <= 2, 1, i == 20);
    check("ovr c2", 32'(o_ovr[2]), 32'd0);
    check("ovr c3", 32'(o_ovr[3]), 32'd1);
    for (int c = 5; c <= 8; c++) check($sformatf("ovr tap c%0d", c), 32'(o_tap[c]), 32'(c - 5));
    check("ovr c20", 32'(o_ovr[20]), 32'd1);
    check("ovr cleared c21", 32'(o_ovr[21]), 32'd0);

    // run low: strobe ignored entirely.
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(i == 0, 0, 0);
    cnt = 0;
    for (int c = 1; c <= 12; c++) cnt += int'(o_busy[c]) + int'(o_ovr[c]);
    check("run0 activity", 32'(cnt), 32'd0);

    // run dropped mid-frame: frame still completes.
    doReset();
    for (int i = 0; i < 14; i++) applyStimulus(i == 0, i < 2, 0);
    check("rundrop tap c4", 32'(o_tap[4]), 32'd3);
    check("rundrop out_valid c11", 32'(o_ov[11]), 32'd1);
    check("rundrop busy c12", 32'(o_busy[12]), 32'd0);

    // Async reset mid-frame, then a fresh frame.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(i == 0, 1, 0);
    doReset();
    for (int i = 0; i < 30; i++) applyStimulus(i == 15, 1, 0);
    cnt = 0;
    for (int c = 1; c <= 25; c++) cnt += int'(o_ov[c]);
    check("abort out_valid count", 32'(cnt), 32'd0);
    check("fresh out_valid c26", 32'(o_ov[26]), 32'd1);

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);

`ifdef FIR_MAC_SCHED_DROP_CNT_EN
    // Saturation of the drop counter, then clear.
    doReset();
    for (int i = 0; i < 500; i++) applyStimulus(1, 1, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0);
    check("drop_cnt saturated", 32'(bus.drop_cnt), 32'd255);
    applyStimulus(0, 1, 1);
    check("drop_cnt cleared", 32'(bus.drop_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
